// File: rtl/debug_dump_uart.sv
// Debug register dump over UART 8N1.
// A start pulse latches the fetch PC. The block then walks debug_reg_select
// through every register and captures each value. It streams
// HEADER, PC[4], R0[4] .. R15[4] out on tx, each word MSB-first.
// The FSM computes each tx bit one cycle ahead; r_tx registers it.
// So tx, done and debug_reg_select all appear one cycle after the FSM state that produces them.
module debug_dump_uart #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NUM_REGS     = 16,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] fetch_pc,
  output logic [3:0]  debug_reg_select,
  input  logic [31:0] debug_reg_out,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TW = 16;
  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] S_IDLE     = 3'd0;
  localparam logic [SW-1:0] S_SEND_HDR = 3'd1;
  localparam logic [SW-1:0] S_SEND_PC  = 3'd2;
  localparam logic [SW-1:0] S_SEL      = 3'd3;
  localparam logic [SW-1:0] S_CAP      = 3'd4;
  localparam logic [SW-1:0] S_SEND_REG = 3'd5;
  localparam logic [SW-1:0] S_FIN      = 3'd6;

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_next_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_bit_idx;
  logic [1:0]    r_byte_idx;
  logic [3:0]    r_reg_idx;
  logic [31:0]   r_buf;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    r_sel;

  logic          w_accept;
  logic          w_sending;
  logic          w_word_state;
  logic          w_bit_end;
  logic          w_byte_end;
  logic          w_word_end;
  logic          w_last_reg;
  logic [7:0]    w_cur_byte;
  logic [2:0]    w_data_idx;
  logic          w_tx_c;

  // Start is ignored while a frame runs and during the done cycle.
  assign w_accept     = (r_state == S_IDLE) && start && !r_done;
  assign w_sending    = (r_state == S_SEND_HDR) || (r_state == S_SEND_PC) ||
                        (r_state == S_SEND_REG);
  assign w_word_state = (r_state == S_SEND_PC) || (r_state == S_SEND_REG);
  assign w_bit_end    = w_sending && (r_timer == TW'(CLKS_PER_BIT - 1));
  assign w_byte_end   = w_bit_end && (r_bit_idx == 4'd9);
  assign w_word_end   = w_byte_end && (r_byte_idx == 2'd3);
  assign w_last_reg   = (r_reg_idx == 4'(NUM_REGS - 1));
  assign w_cur_byte   = (r_state == S_SEND_HDR) ? HEADER : r_buf[31:24];
  assign w_data_idx   = 3'(r_bit_idx - 4'd1);

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next_state = S_SEND_HDR;
      S_SEND_HDR: if (w_byte_end) w_next_state = S_SEND_PC;
      S_SEND_PC:  if (w_word_end) w_next_state = S_SEL;
      S_SEL:      w_next_state = S_CAP;
      S_CAP:      w_next_state = S_SEND_REG;
      S_SEND_REG: if (w_word_end) w_next_state = w_last_reg ? S_FIN : S_SEL;
      S_FIN:      w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Serial bit for the current slot: start, 8 data bits LSB-first, stop
  always_comb begin
    w_tx_c = 1'b1;
    if (w_sending) begin
      case (r_bit_idx)
        4'd0:    w_tx_c = 1'b0;
        4'd9:    w_tx_c = 1'b1;
        default: w_tx_c = w_cur_byte[w_data_idx];
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Bit timer and bit index; both park at zero outside send states
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer   <= '0;
      r_bit_idx <= '0;
    end else if (w_sending) begin
      r_timer <= w_bit_end ? '0 : r_timer + TW'(1);
      if (w_bit_end) r_bit_idx <= (r_bit_idx == 4'd9) ? 4'd0 : r_bit_idx + 4'd1;
    end else begin
      r_timer   <= '0;
      r_bit_idx <= '0;
    end
  end

  // Word shift buffer, byte index and register index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf      <= '0;
      r_byte_idx <= '0;
      r_reg_idx  <= '0;
    end else if (w_accept) begin
      r_buf      <= fetch_pc;
      r_byte_idx <= '0;
      r_reg_idx  <= '0;
    end else if (r_state == S_CAP) begin
      r_buf <= debug_reg_out;
    end else if (w_byte_end && w_word_state) begin
      r_buf      <= {r_buf[23:0], 8'h00};
      r_byte_idx <= r_byte_idx + 2'd1;
      if ((r_state == S_SEND_REG) && (r_byte_idx == 2'd3))
        r_reg_idx <= w_last_reg ? 4'd0 : r_reg_idx + 4'd1;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sel  <= '0;
    end else begin
      r_tx   <= w_tx_c;
      r_done <= (r_state == S_FIN);
      if (w_accept)              r_busy <= 1'b1;
      else if (r_state == S_FIN) r_busy <= 1'b0;
      if (r_state == S_SEL)      r_sel <= r_reg_idx;
      else if (r_state == S_FIN) r_sel <= '0;
    end
  end

  assign tx               = r_tx;
  assign busy             = r_busy;
  assign done             = r_done;
  assign debug_reg_select = r_sel;

endmodule

// File: tb/tb_debug_dump_uart.sv
// Directed bench for debug_dump_uart with CLKS_PER_BIT=4 and a UART decoder.
module tb_debug_dump_uart;

  localparam int unsigned CPB          = 4;
  localparam int unsigned FRAME_BYTES  = 69;
  localparam int unsigned BYTE_TIMEOUT = 200;
  localparam int          DONE_LAT     = 690 * 4 + 32 + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] fetch_pc;
  logic [3:0]  debug_reg_select;
  logic [31:0] debug_reg_out;
  logic        tx;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  logic [31:0] regs [16];
  bit          sel_mode = 1'b0;
  logic [3:0]  last_sel;
  logic [3:0]  sel_prev_n;
  logic [3:0]  sel_log [$];
  logic [7:0]  rx_buf  [FRAME_BYTES];
  logic [7:0]  exp_buf [FRAME_BYTES];

  debug_dump_uart #(.CLKS_PER_BIT(CPB), .NUM_REGS(16), .HEADER(8'hA5)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .fetch_pc         (fetch_pc),
    .debug_reg_select (debug_reg_select),
    .debug_reg_out    (debug_reg_out),
    .tx               (tx),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(posedge clk) last_sel <= debug_reg_select;

  // Register file model; sel_mode returns the index only in the cycle after select moves
  assign debug_reg_out = sel_mode ?
      (((debug_reg_select == 4'd0) || (debug_reg_select != last_sel)) ?
         {28'h0, debug_reg_select} : 32'hDEAD_BEEF) :
      regs[debug_reg_select];

  // Done pulse and select-change monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (debug_reg_select != sel_prev_n) sel_log.push_back(debug_reg_select);
    sel_prev_n = debug_reg_select;
  end

  task automatic load_basic_regs();
    for (int n = 0; n < 16; n++) regs[n] = 32'h1111_1111 * n;
  endtask

  task automatic build_exp(input logic [31:0] pc, input bit idx_mode);
    logic [31:0] w;
    exp_buf[0] = 8'hA5;
    for (int b = 0; b < 4; b++) exp_buf[1 + b] = pc[31 - 8 * b -: 8];
    for (int r = 0; r < 16; r++) begin
      w = idx_mode ? 32'(r) : regs[r];
      for (int b = 0; b < 4; b++) exp_buf[5 + 4 * r + b] = w[31 - 8 * b -: 8];
    end
  endtask

  task automatic start_frame(output int k_cyc);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k_cyc = cyc;
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b1;
    b  = 8'h00;
    while (tx !== 1'b0 && n < BYTE_TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_range(input int first, input int last, input string name);
    bit ok;
    for (int i = first; i <= last; i++) begin
      rx_byte(rx_buf[i], ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL %s rx byte %0d: framing error or no start bit, required valid byte", name, i);
        return;
      end
    end
  endtask

  task automatic check_frame(input string name);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      checks++;
      if (rx_buf[i] !== exp_buf[i]) begin
        failures++;
        $display("FAIL %s byte %0d: got %02h required %02h", name, i, rx_buf[i], exp_buf[i]);
      end
    end
  endtask

  task automatic wait_done(input int d_before, input int max, input string name);
    int n = 0;
    while (done_cnt == d_before && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == d_before) begin
      failures++;
      $display("FAIL %s done timeout: done_cnt=%0d required >%0d", name, done_cnt, d_before);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    fetch_pc = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, done, debug_reg_select} !== 7'b1_0_0_0000) begin
      failures++;
      $display("FAIL reset_hold tx/busy/done/sel: got %b%b%b %h required 100 0", tx, busy, done, debug_reg_select);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, done, debug_reg_select} !== 7'b1_0_0_0000) begin
      failures++;
      $display("FAIL reset_release tx/busy/done/sel: got %b%b%b %h required 100 0", tx, busy, done, debug_reg_select);
    end
  endtask

  task automatic test_basic();
    int k, d0;
    load_basic_regs();
    sel_mode = 1'b0;
    fetch_pc = 32'h0000_0040;
    d0 = done_cnt;
    start_frame(k);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL basic accept: busy=%b tx=%b required busy=1 tx=1", busy, tx);
    end
    rx_range(0, FRAME_BYTES - 1, "basic");
    build_exp(32'h0000_0040, 1'b0);
    check_frame("basic");
    checks++;
    if (rx_buf[4] !== 8'h40 || rx_buf[68] !== 8'hFF || rx_buf[9] !== 8'h11) begin
      failures++;
      $display("FAIL basic literal bytes: got %02h %02h %02h required 40 11 FF", rx_buf[4], rx_buf[9], rx_buf[68]);
    end
    wait_done(d0, 50, "basic");
    checks++;
    if (done_cyc - k != DONE_LAT) begin
      failures++;
      $display("FAIL basic done latency: got %0d required %0d", done_cyc - k, DONE_LAT);
    end
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic done count/busy: got %0d busy=%b required 1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_header_timing();
    int k, d0;
    logic [10:0] pat;
    logic        exp;
    pat = 11'b01101001010;
    fetch_pc = 32'h0000_0000;
    d0 = done_cnt;
    start_frame(k);
    for (int j = 1; j <= 44; j++) begin
      @(negedge clk);
      exp = pat[(j - 1) / 4];
      checks++;
      if (tx !== exp) begin
        failures++;
        $display("FAIL header_timing cycle %0d: tx=%b required %b", j, tx, exp);
      end
    end
    wait_done(d0, 3000, "header_timing");
  endtask

  task automatic test_select_capture();
    int k, d0;
    sel_mode = 1'b1;
    fetch_pc = 32'h8000_0004;
    sel_log.delete();
    d0 = done_cnt;
    start_frame(k);
    rx_range(0, FRAME_BYTES - 1, "select");
    build_exp(32'h8000_0004, 1'b1);
    check_frame("select");
    wait_done(d0, 50, "select");
    checks++;
    if (sel_log.size() != 16) begin
      failures++;
      $display("FAIL select_seq length: got %0d required 16", sel_log.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (sel_log[i] !== 4'((i + 1) % 16)) begin
          failures++;
          $display("FAIL select_seq step %0d: got %0d required %0d", i, sel_log[i], (i + 1) % 16);
        end
      end
    end
    sel_mode = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int k, d0, n;
    load_basic_regs();
    fetch_pc = 32'h0000_3000;
    d0 = done_cnt;
    start_frame(k);
    rx_range(0, 29, "busy_start");
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    rx_range(30, FRAME_BYTES - 1, "busy_start");
    build_exp(32'h0000_3000, 1'b0);
    check_frame("busy_start");
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL fin_start_ignored: busy=%b done=%b pulses=%0d required 0 0 1", busy, done, done_cnt - d0);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL after_fin_accept: busy=%b tx=%b required 1 1", busy, tx);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL after_fin_start_bit: tx=%b required 0", tx);
    end
    rx_range(0, FRAME_BYTES - 1, "second_frame");
    check_frame("second_frame");
    wait_done(d0 + 1, 50, "second_frame");
    checks++;
    if (done_cnt - d0 != 2) begin
      failures++;
      $display("FAIL busy_start done pulses: got %0d required 2", done_cnt - d0);
    end
  endtask

  task automatic test_live_core();
    int k, d0;
    load_basic_regs();
    fetch_pc = 32'hCAFE_0100;
    d0 = done_cnt;
    start_frame(k);
    fetch_pc = 32'h1234_5678;
    rx_range(0, 17, "live");
    regs[5] = 32'h5A5A_0005;
    rx_range(18, FRAME_BYTES - 1, "live");
    build_exp(32'hCAFE_0100, 1'b0);
    check_frame("live");
    checks++;
    if ({rx_buf[25], rx_buf[26], rx_buf[27], rx_buf[28]} !== 32'h5A5A_0005) begin
      failures++;
      $display("FAIL live R5 word: got %02h%02h%02h%02h required 5a5a0005", rx_buf[25], rx_buf[26], rx_buf[27], rx_buf[28]);
    end
    wait_done(d0, 50, "live");
  endtask

  task automatic test_reset_mid_frame();
    int k, d0, n;
    load_basic_regs();
    fetch_pc = 32'h0000_1000;
    d0 = done_cnt;
    start_frame(k);
    rx_range(0, 9, "midreset");
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL midreset data bit before reset: tx=%b required 0", tx);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset async: tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3000) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0 || tx !== 1'b1 || debug_reg_select !== 4'd0) begin
      failures++;
      $display("FAIL midreset abandon: pulses=%0d busy=%b tx=%b sel=%0d required 0 0 1 0", done_cnt - d0, busy, tx, debug_reg_select);
    end
    fetch_pc = 32'h0000_2000;
    start_frame(k);
    rx_range(0, FRAME_BYTES - 1, "post_reset");
    build_exp(32'h0000_2000, 1'b0);
    check_frame("post_reset");
    wait_done(d0, 50, "post_reset");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_header_timing();
    test_select_capture();
    test_start_while_busy();
    test_live_core();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
